// File: rtl/html_tokenizer.sv
// Streaming HTML tokenizer: consumes one reader char per accepted cycle and emits
// open/close/attribute/text/end tokens on a ready/valid port, with a one-entry skid.
module html_tokenizer #(
    parameter int unsigned MAX_NAME = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       state_enable,
    input  logic [7:0] char,
    input  logic       src_finished,
    output logic       pause,
    output logic       token_valid,
    input  logic       token_ready,
    output logic [2:0] token_type,
    output logic [2:0] token_tag,
    output logic [1:0] token_attr,
    output logic [7:0] token_value,
    output logic       has_finished,
    output logic       error
);
    localparam int unsigned LEN_W   = $clog2(MAX_NAME + 2);
    localparam int unsigned N_NAMES = 5;

    localparam logic [2:0] T_OPEN  = 3'd1;
    localparam logic [2:0] T_CLOSE = 3'd2;
    localparam logic [2:0] T_ATTR  = 3'd3;
    localparam logic [2:0] T_TEXT  = 3'd4;
    localparam logic [2:0] T_END   = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_TEXT, S_TAG_START, S_TAG_NAME, S_CLOSE_NAME,
        S_ATTR_WS, S_ATTR_NAME, S_ATTR_EQ, S_ATTR_VALUE, S_DONE
    } state_t;

    // Known names: 0 body, 1 p (tags); 2 background, 3 color, 4 size (attributes).
    function automatic int unsigned name_len(input int unsigned idx);
        case (idx)
            0:       name_len = 4;
            1:       name_len = 1;
            2:       name_len = 10;
            3:       name_len = 5;
            4:       name_len = 4;
            default: name_len = 0;
        endcase
    endfunction

    function automatic logic [7:0] name_char(input int unsigned idx, input int unsigned pos);
        logic [79:0]  s;
        int unsigned  l;
        s = '0;
        case (idx)
            0:       s = 80'("body");
            1:       s = 80'("p");
            2:       s = 80'("background");
            3:       s = 80'("color");
            4:       s = 80'("size");
            default: s = '0;
        endcase
        l = name_len(idx);
        if (pos < l) s = s >> (8 * (l - 1 - pos));
        else         s = '0;
        name_char = s[7:0];
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         skid_q, skid_d;
    logic               skid_full_q, skid_full_d;
    logic               accept_q, accept_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [N_NAMES-1:0] mask_q, mask_d;
    logic [7:0]         value_q, value_d;
    logic [1:0]         attr_id_q, attr_id_d;
    logic               tok_valid_q, tok_valid_d;
    logic [2:0]         tok_type_q, tok_type_d;
    logic [2:0]         tok_tag_q, tok_tag_d;
    logic [1:0]         tok_attr_q, tok_attr_d;
    logic [7:0]         tok_value_q, tok_value_d;
    logic               fin_q, fin_d;
    logic               err_q, err_d;

    logic               unused_ok;
    assign unused_ok = src_finished;

    logic               new_c, slot_free_c, do_proc_c, bad_c, emit_c;
    logic [7:0]         ch_c;
    logic               is_letter_c, is_digit_c;
    logic [N_NAMES-1:0] mask_first_c, mask_acc_c, hit_c;
    logic [LEN_W-1:0]   len_acc_c;
    logic [2:0]         tag_id_c, e_type_c, e_tag_c;
    logic [1:0]         attr_id_c, e_attr_c;
    logic [7:0]         e_value_c;
    logic [11:0]        prod_c;

    assign pause       = skid_full_q | (tok_valid_q & ~token_ready) | fin_q;
    assign new_c       = accept_q & state_enable;
    assign slot_free_c = ~tok_valid_q | token_ready;
    assign ch_c        = skid_full_q ? skid_q : char;
    assign is_letter_c = (ch_c >= "a" && ch_c <= "z") || (ch_c >= "A" && ch_c <= "Z");
    assign is_digit_c  = (ch_c >= "0" && ch_c <= "9");

    // Incremental position-by-position name matching against every known name.
    always_comb begin
        mask_first_c = '0;
        mask_acc_c   = '0;
        hit_c        = '0;
        for (int unsigned i = 0; i < N_NAMES; i++) begin
            mask_first_c[i] = (ch_c == name_char(i, 0));
            mask_acc_c[i]   = mask_q[i] & (ch_c == name_char(i, 32'(len_q)));
            hit_c[i]        = mask_q[i] && (32'(len_q) == name_len(i)) && (32'(len_q) <= MAX_NAME);
        end
        len_acc_c = (32'(len_q) >= MAX_NAME) ? LEN_W'(MAX_NAME + 1) : len_q + LEN_W'(1);
        tag_id_c  = hit_c[0] ? 3'd1 : (hit_c[1] ? 3'd2 : 3'd7);
        attr_id_c = hit_c[2] ? 2'd1 : (hit_c[3] ? 2'd2 : (hit_c[4] ? 2'd3 : 2'd0));
        prod_c    = 12'(value_q) * 12'd10 + 12'(ch_c - 8'h30);
    end

    // Next-state, skid and token-slot logic.
    always_comb begin
        state_d     = state_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        accept_d    = state_enable & ~pause;
        len_d       = len_q;
        mask_d      = mask_q;
        value_d     = value_q;
        attr_id_d   = attr_id_q;
        tok_valid_d = tok_valid_q & ~token_ready;
        tok_type_d  = tok_type_q;
        tok_tag_d   = tok_tag_q;
        tok_attr_d  = tok_attr_q;
        tok_value_d = tok_value_q;
        fin_d       = fin_q | (tok_valid_q & token_ready & (tok_type_q == T_END));
        err_d       = err_q;
        do_proc_c   = 1'b0;
        bad_c       = 1'b0;
        emit_c      = 1'b0;
        e_type_c    = '0;
        e_tag_c     = '0;
        e_attr_c    = '0;
        e_value_c   = '0;

        if (state_q != S_DONE && (skid_full_q || new_c)) begin
            if (slot_free_c) begin
                do_proc_c   = 1'b1;
                skid_full_d = 1'b0;
            end else if (!skid_full_q) begin
                skid_d      = char;
                skid_full_d = 1'b1;
            end
        end

        if (do_proc_c) begin
            case (state_q)
                S_IDLE, S_TEXT: begin
                    if (ch_c == "<") begin
                        state_d = S_TAG_START;
                    end else if (ch_c == 8'h00) begin
                        // Leading NULs in IDLE are dropped; in TEXT they end the document.
                        if (state_q == S_TEXT) begin
                            emit_c   = 1'b1;
                            e_type_c = T_END;
                            state_d  = S_DONE;
                        end
                    end else begin
                        emit_c    = 1'b1;
                        e_type_c  = T_TEXT;
                        e_value_c = ch_c;
                        state_d   = S_TEXT;
                    end
                end
                S_TAG_START: begin
                    if (ch_c == "/") begin
                        len_d   = '0;
                        mask_d  = '1;
                        state_d = S_CLOSE_NAME;
                    end else if (is_letter_c) begin
                        len_d   = LEN_W'(1);
                        mask_d  = mask_first_c;
                        state_d = S_TAG_NAME;
                    end else begin
                        bad_c = 1'b1;
                    end
                end
                S_TAG_NAME: begin
                    if (is_letter_c) begin
                        len_d  = len_acc_c;
                        mask_d = mask_acc_c;
                    end else if (ch_c == " " || ch_c == ">") begin
                        emit_c   = 1'b1;
                        e_type_c = T_OPEN;
                        e_tag_c  = tag_id_c;
                        state_d  = (ch_c == " ") ? S_ATTR_WS : S_TEXT;
                    end else begin
                        bad_c = 1'b1;
                    end
                end
                S_CLOSE_NAME: begin
                    if (is_letter_c) begin
                        len_d  = len_acc_c;
                        mask_d = mask_acc_c;
                    end else if (ch_c == ">") begin
                        emit_c   = 1'b1;
                        e_type_c = T_CLOSE;
                        e_tag_c  = tag_id_c;
                        state_d  = S_TEXT;
                    end else begin
                        bad_c = 1'b1;
                    end
                end
                S_ATTR_WS: begin
                    if (ch_c == " ") begin
                        state_d = S_ATTR_WS;
                    end else if (is_letter_c) begin
                        len_d   = LEN_W'(1);
                        mask_d  = mask_first_c;
                        state_d = S_ATTR_NAME;
                    end else if (ch_c == ">") begin
                        state_d = S_TEXT;
                    end else begin
                        bad_c = 1'b1;
                    end
                end
                S_ATTR_NAME: begin
                    if (is_letter_c) begin
                        len_d  = len_acc_c;
                        mask_d = mask_acc_c;
                    end else if (ch_c == "=") begin
                        attr_id_d = attr_id_c;
                        value_d   = '0;
                        state_d   = S_ATTR_VALUE;
                    end else begin
                        bad_c = 1'b1;
                    end
                end
                S_ATTR_VALUE: begin
                    if (is_digit_c) begin
                        value_d = (prod_c > 12'd255) ? 8'hFF : prod_c[7:0];
                    end else if (ch_c == " " || ch_c == ">") begin
                        emit_c    = 1'b1;
                        e_type_c  = T_ATTR;
                        e_attr_c  = attr_id_q;
                        e_value_c = value_q;
                        state_d   = (ch_c == " ") ? S_ATTR_WS : S_TEXT;
                    end else begin
                        bad_c = 1'b1;
                    end
                end
                default: state_d = S_TEXT;
            endcase

            // Syntax error drops the partial token; a NUL still terminates the document.
            if (bad_c) begin
                err_d = 1'b1;
                if (ch_c == 8'h00) begin
                    emit_c   = 1'b1;
                    e_type_c = T_END;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_TEXT;
                end
            end
        end

        if (emit_c) begin
            tok_valid_d = 1'b1;
            tok_type_d  = e_type_c;
            tok_tag_d   = e_tag_c;
            tok_attr_d  = e_attr_c;
            tok_value_d = e_value_c;
        end

        if (!state_enable) begin
            state_d     = S_IDLE;
            skid_d      = '0;
            skid_full_d = 1'b0;
            accept_d    = 1'b0;
            len_d       = '0;
            mask_d      = '0;
            value_d     = '0;
            attr_id_d   = '0;
            tok_valid_d = 1'b0;
            tok_type_d  = '0;
            tok_tag_d   = '0;
            tok_attr_d  = '0;
            tok_value_d = '0;
            fin_d       = 1'b0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            accept_q    <= 1'b0;
            len_q       <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            attr_id_q   <= '0;
            tok_valid_q <= 1'b0;
            tok_type_q  <= '0;
            tok_tag_q   <= '0;
            tok_attr_q  <= '0;
            tok_value_q <= '0;
            fin_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            accept_q    <= accept_d;
            len_q       <= len_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            attr_id_q   <= attr_id_d;
            tok_valid_q <= tok_valid_d;
            tok_type_q  <= tok_type_d;
            tok_tag_q   <= tok_tag_d;
            tok_attr_q  <= tok_attr_d;
            tok_value_q <= tok_value_d;
            fin_q       <= fin_d;
            err_q       <= err_d;
        end
    end

    assign token_valid  = tok_valid_q;
    assign token_type   = tok_type_q;
    assign token_tag    = tok_tag_q;
    assign token_attr   = tok_attr_q;
    assign token_value  = tok_value_q;
    assign has_finished = fin_q;
    assign error        = err_q;

endmodule

// File: tb/tb_html_tokenizer.sv
// Bench for html_tokenizer: drives char streams through a reader model and compares the
// token stream and flags with a recursive-descent reference parser.
module tb_html_tokenizer;
    typedef logic [7:0] ch_t;
    typedef ch_t chq_t[$];
    typedef logic [15:0] tok_t;   // {type[2:0], tag[2:0], attr[1:0], value[7:0]}
    typedef tok_t tokq_t[$];

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       state_enable = 1'b0;
    logic [7:0] char_i = 8'h00;
    logic       src_finished = 1'b0;
    logic       token_ready = 1'b0;
    logic       pause, token_valid, has_finished, error;
    logic [2:0] token_type, token_tag;
    logic [1:0] token_attr;
    logic [7:0] token_value;

    int errors = 0;
    int checks = 0;

    chq_t  ms;
    int    mi;
    tokq_t model_q;
    bit    model_err;

    html_tokenizer #(.MAX_NAME(10)) dut (
        .clock(clock), .reset(reset), .state_enable(state_enable), .char(char_i),
        .src_finished(src_finished), .pause(pause), .token_valid(token_valid),
        .token_ready(token_ready), .token_type(token_type), .token_tag(token_tag),
        .token_attr(token_attr), .token_value(token_value),
        .has_finished(has_finished), .error(error)
    );

    always #5 clock = ~clock;

    function automatic tok_t mk(input int t, input int g, input int a, input int v);
        mk = {3'(t), 3'(g), 2'(a), 8'(v)};
    endfunction

    function automatic bit is_letter(input ch_t c);
        is_letter = (c >= "a" && c <= "z") || (c >= "A" && c <= "Z");
    endfunction

    function automatic bit is_digit(input ch_t c);
        is_digit = (c >= "0" && c <= "9");
    endfunction

    function automatic string read_word();
        string w = "";
        while (mi < ms.size() && is_letter(ms[mi])) begin
            w = $sformatf("%s%c", w, ms[mi]);
            mi++;
        end
        return w;
    endfunction

    function automatic int tag_id(input string w);
        if (w == "body") return 1;
        if (w == "p") return 2;
        return 7;
    endfunction

    function automatic int attr_id(input string w);
        if (w == "background") return 1;
        if (w == "color") return 2;
        if (w == "size") return 3;
        return 0;
    endfunction

    // Attribute list after "<name ": 1 when closed by '>', 0 with mi on the offending char.
    function automatic bit attr_list();
        string w;
        int    v;
        forever begin
            if (ms[mi] == " ") begin
                mi++;
            end else if (ms[mi] == ">") begin
                mi++;
                return 1;
            end else if (!is_letter(ms[mi])) begin
                return 0;
            end else begin
                w = read_word();
                if (ms[mi] != "=") return 0;
                mi++;
                v = 0;
                while (is_digit(ms[mi])) begin
                    v = v * 10 + int'(ms[mi]) - 48;
                    if (v > 255) v = 255;
                    mi++;
                end
                if (ms[mi] != " " && ms[mi] != ">") return 0;
                model_q.push_back(mk(3, 0, attr_id(w), v));
                mi++;
                if (ms[mi - 1] == ">") return 1;
            end
        end
    endfunction

    function automatic void ref_model();
        string w;
        bit    bad;
        ch_t   c;
        model_q.delete();
        model_err = 0;
        mi = 0;
        while (mi < ms.size() && ms[mi] == 8'h00) mi++;
        while (mi < ms.size()) begin
            c = ms[mi];
            if (c == 8'h00) begin
                model_q.push_back(mk(5, 0, 0, 0));
                return;
            end
            if (c != "<") begin
                model_q.push_back(mk(4, 0, 0, int'(c)));
                mi++;
                continue;
            end
            mi++;
            bad = 1;
            c = ms[mi];
            if (c == "/") begin
                mi++;
                w = read_word();
                if (ms[mi] == ">") begin
                    model_q.push_back(mk(2, tag_id(w), 0, 0));
                    mi++;
                    bad = 0;
                end
            end else if (is_letter(c)) begin
                w = read_word();
                c = ms[mi];
                if (c == ">" || c == " ") begin
                    model_q.push_back(mk(1, tag_id(w), 0, 0));
                    mi++;
                    bad = (c == ">") ? 1'b0 : !attr_list();
                end
            end
            if (bad) begin
                model_err = 1;
                if (ms[mi] == 8'h00) begin
                    model_q.push_back(mk(5, 0, 0, 0));
                    return;
                end
                mi++;
            end
        end
    endfunction

    task automatic str2q(input string s, output chq_t q);
        q.delete();
        for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
        q.push_back(8'h00);
    endtask

    // Reader model: presents the next char only on cycles the tokenizer accepts; junk otherwise.
    task automatic run_stream(input string name, input chq_t s, input int mode, input int stop_after,
                              output tokq_t q, output bit done);
        int   ptr = 0;
        bit   adv;
        bit   stall = 0;
        tok_t stall_tok, cur;
        q.delete();
        done = 0;
        @(posedge clock); #1;
        state_enable = 1'b0;
        token_ready = 1'b0;
        @(posedge clock); #1;
        state_enable = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            cur = {token_type, token_tag, token_attr, token_value};
            if (stall) begin
                checks++;
                if (token_valid !== 1'b1 || cur !== stall_tok) begin
                    errors++;
                    $display("FAIL %s hold: got valid=%b tok=%h want valid=1 tok=%h", name, token_valid, cur, stall_tok);
                end
            end
            if (token_valid && !token_ready) begin
                checks++;
                if (pause !== 1'b1) begin
                    errors++;
                    $display("FAIL %s pause_slot_full: got %b want 1", name, pause);
                end
            end
            stall = token_valid && !token_ready;
            stall_tok = cur;
            if (token_valid && token_ready) q.push_back(cur);
            if (has_finished) begin
                done = 1;
                break;
            end
            if (stop_after >= 0 && ptr >= stop_after) break;
            adv = state_enable && !pause;
            @(posedge clock); #1;
            if (adv) begin
                char_i = (ptr < s.size()) ? s[ptr] : 8'($urandom);
                ptr++;
            end else begin
                char_i = 8'($urandom);
            end
            case (mode)
                0:       token_ready = 1'b1;
                1:       token_ready = ((cyc / 3) % 2) == 0;
                default: token_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic check_stream(input string name, input chq_t s, input int mode);
        tokq_t q;
        bit    done;
        ms = s;
        ref_model();
        run_stream(name, s, mode, -1, q, done);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s has_finished: got 0 want 1 within cycle budget", name);
        end
        checks++;
        if (q.size() != model_q.size()) begin
            errors++;
            $display("FAIL %s token_count: got %0d want %0d", name, q.size(), model_q.size());
        end
        for (int k = 0; k < q.size() && k < model_q.size(); k++) begin
            checks++;
            if (q[k] !== model_q[k]) begin
                errors++;
                $display("FAIL %s tok[%0d]: got %h want %h", name, k, q[k], model_q[k]);
            end
        end
        checks++;
        if (error !== model_err) begin
            errors++;
            $display("FAIL %s error_flag: got %b want %b", name, error, model_err);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic [20:0] got;
        got = {pause, token_valid, token_type, token_tag, token_attr, token_value, has_finished, error};
        checks++;
        if (got !== 21'd0) begin
            errors++;
            $display("FAIL %s outputs: got %h want 0", name, got);
        end
        checks++;
        if (token_valid !== 1'b0 || has_finished !== 1'b0) begin
            errors++;
            $display("FAIL %s valid/finished: got %b/%b want 0/0", name, token_valid, has_finished);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
    endtask

    task automatic test_full_stream();
        chq_t s;
        str2q("<body background=3><p color=1 size=2>test</p></body>", s);
        check_stream("full_ready", s, 0);
    endtask

    task automatic test_backpressure();
        chq_t s;
        str2q("<body background=3><p color=1 size=2>test</p></body>", s);
        check_stream("full_toggle", s, 1);
    endtask

    task automatic test_boundaries();
        chq_t s;
        str2q("<p size=300>", s);
        check_stream("saturate", s, 0);
        str2q("<div>", s);
        check_stream("unknown_tag", s, 2);
        str2q("<p color=x>", s);
        check_stream("bad_value", s, 0);
        str2q("<abcdefghijkl background=7 backgrounds=2>x</body>", s);
        check_stream("long_names", s, 1);
    endtask

    task automatic test_reset_mid();
        chq_t  s;
        tokq_t q;
        bit    done;
        str2q("<body backgr", s);
        run_stream("reset_mid", s, 0, 12, q, done);
        #2 reset = 1'b1;
        #1 check_outputs_zero("reset_mid_async");
        @(posedge clock); #1;
        check_outputs_zero("reset_mid_edge");
        reset = 1'b0;
        str2q("<p>", s);
        check_stream("after_reset", s, 0);
    endtask

    task automatic test_leading_nul();
        chq_t s;
        s = {8'h00, 8'h00, 8'h00, "a", 8'h00};
        check_stream("leading_nul", s, 2);
    endtask

    task automatic test_random();
        chq_t  s;
        string p;
        for (int r = 0; r < 25; r++) begin
            s.delete();
            repeat ($urandom_range(0, 2)) s.push_back(8'h00);
            repeat ($urandom_range(3, 12)) begin
                case ($urandom_range(0, 19))
                    0:  p = "<body";
                    1:  p = "<p";
                    2:  p = "<div";
                    3:  p = "</p>";
                    4:  p = "</body>";
                    5:  p = " background=";
                    6:  p = " color=";
                    7:  p = " size=";
                    8:  p = "3";
                    9:  p = "42";
                    10: p = "300";
                    11: p = ">";
                    12: p = " ";
                    13: p = "ab";
                    14: p = "=";
                    15: p = "<";
                    16: p = "/";
                    17: p = "<p size=9 color=12>hi";
                    18: p = "Q";
                    default: p = "<body background=250>";
                endcase
                for (int k = 0; k < p.len(); k++) s.push_back(p[k]);
            end
            s.push_back(8'h00);
            check_stream($sformatf("rand%0d", r), s, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_backpressure();
        test_boundaries();
        test_reset_mid();
        test_leading_nul();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
